// File: rtl/eeprom_arbiter_if.sv
// rtl/eeprom_arbiter_if.sv - requester and converter handshake bundle for eeprom_arbiter
interface eeprom_arbiter_if;
    logic        REQ0;
    logic        REQ1;
    logic        WNR0;
    logic        WNR1;
    logic [10:0] ADDR0;
    logic [10:0] ADDR1;
    logic [7:0]  WDATA0;
    logic [7:0]  WDATA1;
    logic        DONE0;
    logic        DONE1;
    logic [7:0]  RDATA0;
    logic [7:0]  RDATA1;
    logic        ERR0;
    logic        ERR1;
    logic        BUSY;
    logic        RD;
    logic        WR;
    logic [10:0] E_ADDR;
    logic        ACK;

    modport slave (
        input  REQ0, REQ1, WNR0, WNR1, ADDR0, ADDR1, WDATA0, WDATA1, ACK,
        output DONE0, DONE1, RDATA0, RDATA1, ERR0, ERR1, BUSY, RD, WR, E_ADDR
    );

    modport master (
        output REQ0, REQ1, WNR0, WNR1, ADDR0, ADDR1, WDATA0, WDATA1, ACK,
        input  DONE0, DONE1, RDATA0, RDATA1, ERR0, ERR1, BUSY, RD, WR, E_ADDR
    );
endinterface

// File: rtl/eeprom_arbiter.sv
// rtl/eeprom_arbiter.sv - two-port round-robin sequencer for the EEPROM_WR converter
// Optional WAIT_ACK watchdog enabled by EEPROM_ARB_TIMEOUT_EN.
module eeprom_arbiter #(
    parameter int GAP_CYCLES = 4
`ifdef EEPROM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic            CLK,
    input  logic            RESET,
    inout  wire  [7:0]      E_DATA,
    eeprom_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_WAIT_ACK, S_DONE, S_GAP
    } state_t;

    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GW       = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

    state_t        state_q, state_d;
    logic          gsel_q, gsel_d;
    logic          ptr_q, ptr_d;
    logic          wnr_q, wnr_d;
    logic          ack_q, ack_d;
    logic [10:0]   e_addr_q, e_addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata0_q, rdata0_d;
    logic [7:0]    rdata1_q, rdata1_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          ack_rise;
    logic          winner;
    logic          drive_bus;

`ifdef EEPROM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    // With both ports requesting, the one not served last wins.
    assign winner   = (bus.REQ0 & bus.REQ1) ? ~ptr_q : bus.REQ1;
    assign ack_rise = bus.ACK & ~ack_q;

    always_comb begin
        state_d  = state_q;
        gsel_d   = gsel_q;
        ptr_d    = ptr_q;
        wnr_d    = wnr_q;
        ack_d    = bus.ACK;
        e_addr_d = e_addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        gap_d    = gap_q;
`ifdef EEPROM_ARB_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.REQ0 | bus.REQ1) begin
                    gsel_d   = winner;
                    ptr_d    = winner;
                    wnr_d    = winner ? bus.WNR1   : bus.WNR0;
                    e_addr_d = winner ? bus.ADDR1  : bus.ADDR0;
                    wdata_d  = winner ? bus.WDATA1 : bus.WDATA0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: state_d = S_PULSE;
            S_PULSE: begin
`ifdef EEPROM_ARB_TIMEOUT_EN
                tmo_d = '0;
`endif
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ack_rise) begin
                    if (!wnr_q) begin
                        if (gsel_q) rdata1_d = E_DATA;
                        else        rdata0_d = E_DATA;
                    end
`ifdef EEPROM_ARB_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    state_d = S_DONE;
                end
`ifdef EEPROM_ARB_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                gap_d   = '0;
                state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_LAST)) state_d = S_IDLE;
                else                        gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            gsel_q   <= 1'b0;
            ptr_q    <= 1'b1;
            wnr_q    <= 1'b0;
            ack_q    <= 1'b0;
            e_addr_q <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            gap_q    <= '0;
`ifdef EEPROM_ARB_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gsel_q   <= gsel_d;
            ptr_q    <= ptr_d;
            wnr_q    <= wnr_d;
            ack_q    <= ack_d;
            e_addr_q <= e_addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            gap_q    <= gap_d;
`ifdef EEPROM_ARB_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    assign drive_bus  = wnr_q & ((state_q == S_SETUP) | (state_q == S_PULSE) |
                                 (state_q == S_WAIT_ACK));
    assign E_DATA     = drive_bus ? wdata_q : 8'bz;
    assign bus.BUSY   = (state_q != S_IDLE);
    assign bus.RD     = (state_q == S_PULSE) & ~wnr_q;
    assign bus.WR     = (state_q == S_PULSE) & wnr_q;
    assign bus.E_ADDR = e_addr_q;
    assign bus.DONE0  = (state_q == S_DONE) & ~gsel_q;
    assign bus.DONE1  = (state_q == S_DONE) & gsel_q;
    assign bus.RDATA0 = rdata0_q;
    assign bus.RDATA1 = rdata1_q;
`ifdef EEPROM_ARB_TIMEOUT_EN
    assign bus.ERR0   = bus.DONE0 & err_q;
    assign bus.ERR1   = bus.DONE1 & err_q;
`else
    assign bus.ERR0   = 1'b0;
    assign bus.ERR1   = 1'b0;
`endif
endmodule

// File: tb/tb_eeprom_arbiter.sv
// tb/tb_eeprom_arbiter.sv - eeprom_arbiter bench: timeline reference model, converter model, directed and random requests
`timescale 1ns/1ps
module tb_eeprom_arbiter;
    localparam int GAP = 4;
`ifdef EEPROM_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`endif

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    wire  [7:0] E_DATA;
    logic       conv_oe   = 1'b0;
    logic [7:0] conv_data = 8'h00;

    assign E_DATA = conv_oe ? conv_data : 8'bz;

    eeprom_arbiter_if bus();

    eeprom_arbiter #(
        .GAP_CYCLES(GAP)
`ifdef EEPROM_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .E_DATA(E_DATA),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, expressed as edge numbers.
    bit         m_active;
    int         m_port, m_g, m_d;
    bit         m_wnr, m_err, m_ptr, m_ack_prev;
    logic [10:0] m_eaddr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata [2];
    int         glog [$];
    int         slog [$];

    task automatic model_reset();
        m_active = 0; m_port = 0; m_g = -100; m_d = -100;
        m_wnr = 0; m_err = 0; m_ptr = 1; m_ack_prev = 0;
        m_eaddr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    initial begin
        bit rise;
        int w;
        model_reset();
        forever begin
            @(posedge CLK);
            cyc++;
            if (RESET) begin
                model_reset();
            end else begin
                rise = bus.ACK && !m_ack_prev;
                m_ack_prev = bus.ACK;
                if (m_active) begin
                    if (cyc >= m_g + 3 && rise) begin
                        m_active = 0; m_d = cyc; m_err = 0;
                        if (!m_wnr) m_rdata[m_port] = conv_oe ? conv_data : 8'h00;
                    end
`ifdef EEPROM_ARB_TIMEOUT_EN
                    else if (cyc == m_g + 3 + TMO) begin
                        m_active = 0; m_d = cyc; m_err = 1;
                    end
`endif
                end else if (cyc >= m_d + GAP + 2 && (bus.REQ0 || bus.REQ1)) begin
                    w = (bus.REQ0 && bus.REQ1) ? (m_ptr ? 0 : 1) : (bus.REQ1 ? 1 : 0);
                    m_ptr = w[0]; m_port = w; m_g = cyc; m_active = 1;
                    m_wnr   = (w == 1) ? bus.WNR1   : bus.WNR0;
                    m_eaddr = (w == 1) ? bus.ADDR1  : bus.ADDR0;
                    m_wdata = (w == 1) ? bus.WDATA1 : bus.WDATA0;
                    glog.push_back(w);
                end
            end
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        bit drv, str, d0, d1;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                check("rst_busy", bus.BUSY, 0);
                check("rst_rd", bus.RD, 0);
                check("rst_wr", bus.WR, 0);
                check("rst_done", {bus.DONE1, bus.DONE0}, 0);
                check("rst_err", {bus.ERR1, bus.ERR0}, 0);
                check("rst_rdata", {bus.RDATA1, bus.RDATA0}, 0);
                check("rst_eaddr", bus.E_ADDR, 0);
            end else begin
                str = m_active && (cyc == m_g + 1);
                drv = m_active && m_wnr && (cyc >= m_g);
                d0  = (cyc == m_d) && (m_port == 0);
                d1  = (cyc == m_d) && (m_port == 1);
                check("busy", bus.BUSY, (m_active || cyc <= m_d + GAP) ? 1 : 0);
                check("rd", bus.RD, (str && !m_wnr) ? 1 : 0);
                check("wr", bus.WR, (str && m_wnr) ? 1 : 0);
                check("done0", bus.DONE0, d0);
                check("done1", bus.DONE1, d1);
                check("err0", bus.ERR0, (d0 && m_err) ? 1 : 0);
                check("err1", bus.ERR1, (d1 && m_err) ? 1 : 0);
                check("rdata0", bus.RDATA0, m_rdata[0]);
                check("rdata1", bus.RDATA1, m_rdata[1]);
                check("e_addr", bus.E_ADDR, m_eaddr);
                if (drv) check("e_data_wr", E_DATA, m_wdata);
                else if (conv_oe) check("e_data_rd", E_DATA, conv_data);
            end
        end
    end

    // Converter model: ACK rises conv_lat cycles after the strobe cycle, held 2 cycles.
    bit         conv_manual = 0;
    bit         man_ack     = 0;
    bit         conv_rand   = 0;
    int         conv_lat    = 3;
    logic [7:0] conv_rd_val = 8'h00;

    initial begin
        int cnt, hold;
        bit pend;
        bus.ACK = 1'b0;
        pend = 0; cnt = 0; hold = 0;
        forever begin
            @(negedge CLK);
            #1;
            if (RESET) begin
                bus.ACK = 1'b0; conv_oe = 1'b0; pend = 0; hold = 0;
            end else begin
                if (bus.RD || bus.WR) slog.push_back(cyc);
                if (conv_manual) begin
                    bus.ACK = man_ack;
                end else begin
                    if (bus.DONE0 || bus.DONE1) conv_oe = 1'b0;
                    if (pend) begin
                        if (cnt == 0) begin bus.ACK = 1'b1; pend = 0; hold = 2; end
                        else cnt--;
                    end else if (hold > 0) begin
                        hold--;
                        if (hold == 0) bus.ACK = 1'b0;
                    end
                    if (bus.RD || bus.WR) begin
                        pend = 1;
                        cnt  = (conv_rand ? $urandom_range(1, 6) : conv_lat) - 1;
                        if (bus.RD) begin
                            conv_oe   = 1'b1;
                            conv_data = conv_rand ? 8'($urandom) : conv_rd_val;
                        end
                    end
                end
            end
        end
    end

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [10:0] a, input logic [7:0] d);
        if (p == 0) begin bus.REQ0 = r; bus.WNR0 = w; bus.ADDR0 = a; bus.WDATA0 = d; end
        else        begin bus.REQ1 = r; bus.WNR1 = w; bus.ADDR1 = a; bus.WDATA1 = d; end
    endtask

    task automatic do_req(input int p, input logic w, input logic [10:0] a, input logic [7:0] d,
                          input bit drop, output int dc, output int rc);
        @(negedge CLK);
        set_port(p, 1'b1, w, a, d);
        rc = cyc;
        dc = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            if ((p == 0 && bus.DONE0) || (p == 1 && bus.DONE1)) begin
                dc = cyc;
                break;
            end
        end
        check("done_wait", (dc >= 0) ? 1 : 0, 1);
        if (drop) set_port(p, 1'b0, w, a, d);
    endtask

    task automatic rand_port(input int p, input int n);
        int dc, rc;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge CLK);
            do_req(p, 1'($urandom), 11'($urandom), 8'($urandom), 1'($urandom), dc, rc);
        end
        set_port(p, 1'b0, 1'b0, 11'h0, 8'h0);
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #2 RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b0;
    endtask

    initial begin
        int dc, rc, gb, sb, r, wc;
        int da [4];
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #2 RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("idle_busy", bus.BUSY, 0);

        // Port 0 write, ACK 20 cycles after WR.
        conv_lat = 20;
        do_req(0, 1'b1, 11'h05A, 8'hC3, 1, dc, rc);
        check("t1_latency", dc - rc, 23);
        check("t1_grant", glog[glog.size()-1], 0);
        check("t1_eaddr", bus.E_ADDR, 11'h05A);
        repeat (8) @(negedge CLK);

        // Port 1 read of the top address.
        conv_lat = 7; conv_rd_val = 8'hA5;
        do_req(1, 1'b0, 11'h7FF, 8'h3C, 1, dc, rc);
        check("t2_rdata1", bus.RDATA1, 8'hA5);
        check("t2_grant", glog[glog.size()-1], 1);
        repeat (8) @(negedge CLK);

        // Both ports held for four commands.
        conv_lat = 3;
        gb = glog.size(); sb = slog.size();
        fork
            begin
                do_req(0, 1'b1, 11'h100, 8'h11, 0, da[0], rc);
                do_req(0, 1'b0, 11'h101, 8'h22, 1, da[2], rc);
            end
            begin
                do_req(1, 1'b1, 11'h200, 8'h33, 0, da[1], rc);
                do_req(1, 1'b0, 11'h201, 8'h44, 1, da[3], rc);
            end
        join
        for (int i = 0; i < 4; i++) check("t3_order", glog[gb+i], i % 2);
        for (int i = 0; i < 3; i++) check("t3_spacing", slog[sb+i+1] - da[i], GAP + 3);
        repeat (8) @(negedge CLK);

        // ACK already high when WAIT_ACK is entered.
        conv_manual = 1; man_ack = 1;
        repeat (2) @(negedge CLK);
        r = -1;
        fork
            do_req(0, 1'b1, 11'h155, 8'h5A, 1, dc, rc);
            begin
                wc = 0;
                while (!bus.WR && wc < 50) begin @(negedge CLK); wc++; end
                check("t4_wr_seen", (wc < 50) ? 1 : 0, 1);
                repeat (4) @(negedge CLK);
                man_ack = 0;
                repeat (5) @(negedge CLK);
                man_ack = 1;
                r = cyc;
            end
        join
        check("t4_done_after_rise", dc - r, 1);
        man_ack = 0;
        repeat (3) @(negedge CLK);
        conv_manual = 0;
        repeat (6) @(negedge CLK);

        // Reset during WAIT_ACK of a write.
        conv_lat = 30;
        @(negedge CLK);
        set_port(0, 1'b1, 1'b1, 11'h2AA, 8'h99);
        wc = 0;
        while (!bus.WR && wc < 50) begin @(negedge CLK); wc++; end
        check("t5_wr_seen", (wc < 50) ? 1 : 0, 1);
        repeat (3) @(negedge CLK);
        set_port(0, 1'b0, 1'b0, 11'h0, 8'h0);
        @(posedge CLK);
        #2 RESET = 1'b1;
        @(negedge CLK);
        check("t5_busy_now", bus.BUSY, 0);
        check("t5_wr_now", bus.WR, 0);
        check("t5_done_now", {bus.DONE1, bus.DONE0}, 0);
        @(posedge CLK);
        #2 RESET = 1'b0;
        conv_lat = 2;
        gb = glog.size();
        fork
            do_req(0, 1'b1, 11'h010, 8'h01, 1, dc, rc);
            do_req(1, 1'b1, 11'h020, 8'h02, 1, dc, rc);
        join
        check("t5_first", glog[gb], 0);
        check("t5_second", glog[gb+1], 1);
        repeat (8) @(negedge CLK);

`ifdef EEPROM_ARB_TIMEOUT_EN
        conv_lat = 2; conv_rd_val = 8'h5C;
        do_req(0, 1'b0, 11'h040, 8'h00, 1, dc, rc);
        check("t6_pre_rdata", bus.RDATA0, 8'h5C);
        repeat (8) @(negedge CLK);
        conv_manual = 1; man_ack = 0;
        do_req(0, 1'b0, 11'h123, 8'h00, 1, dc, rc);
        check("t6_timeout_at", dc - slog[slog.size()-1], 18);
        check("t6_err0", bus.ERR0, 1);
        check("t6_rdata_kept", bus.RDATA0, 8'h5C);
        conv_manual = 0;
        repeat (8) @(negedge CLK);
`else
        conv_manual = 1; man_ack = 0;
        @(negedge CLK);
        set_port(0, 1'b1, 1'b0, 11'h123, 8'h00);
        repeat (60) @(negedge CLK);
        check("t6_stuck_busy", bus.BUSY, 1);
        set_port(0, 1'b0, 1'b0, 11'h0, 8'h0);
        pulse_reset();
        conv_manual = 0;
        repeat (3) @(negedge CLK);
`endif

        // Random traffic on both ports.
        conv_rand = 1;
        fork
            rand_port(0, 25);
            rand_port(1, 25);
        join
        repeat (12) @(negedge CLK);
        check("final_idle", bus.BUSY, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
